// File: rtl/ej32_mem_dump.sv
// SPRAM-to-host byte streamer: reads a block of bytes over the 8-bit memory bus
// and presents them on a valid/ready stream through a small skid FIFO.
module ej32_mem_dump #(
  parameter int ASZ    = 17,
  parameter int FIFO_D = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] base,
  input  logic [ASZ-1:0] len,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_re,
  input  logic [7:0]     mem_d,
  output logic [7:0]     tx_d,
  output logic           tx_vld,
  input  logic           tx_rdy,
  output logic [ASZ-1:0] sent
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]     state;
  logic [ASZ-1:0] addr;
  logic [ASZ-1:0] rem;
  logic [ASZ-1:0] last_a;
  logic           inflight;
  logic           done_q;
  logic [ASZ-1:0] sent_q;

  logic [7:0]     fifo_mem [FIFO_D];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  fifo_cnt;

  logic           pop;
  logic           push;
  logic           issue;
  logic           finish;
  logic [CW:0]    occupancy;
  logic [CW-1:0]  cnt_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Abort wins over a same-cycle handshake: that byte is not counted as delivered.
  assign tx_vld = (fifo_cnt != '0);
  assign pop    = tx_vld && tx_rdy && !abort;
  assign push   = inflight;

  // Room check uses the post-pop count so a draining FIFO still issues every cycle.
  assign occupancy = (CW+1)'(fifo_cnt) - (CW+1)'(pop) + (CW+1)'(inflight);
  assign issue     = (state == ST_RUN) && (rem != '0) && (occupancy < (CW+1)'(FIFO_D));
  assign cnt_next  = fifo_cnt + CW'(push) - CW'(pop);
  assign finish    = (state != ST_IDLE) && (rem == '0) && !inflight &&
                     (cnt_next == '0) && !abort;

  assign mem_re = issue;
  assign mem_a  = issue ? addr : last_a;
  assign busy   = (state != ST_IDLE);
  assign done   = done_q;
  assign sent   = sent_q;
  assign tx_d   = tx_vld ? fifo_mem[rd_ptr] : 8'h00;

  // NOTE: FIFO storage has no reset; tx_d is gated by tx_vld so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_d;
  end

  // NOTE: all state here uses <= so every read below sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      rem      <= '0;
      last_a   <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      sent_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      fifo_cnt <= cnt_next;
      if (issue) begin
        addr   <= addr + 1'b1;
        rem    <= rem - 1'b1;
        last_a <= addr;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        sent_q <= sent_q + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            sent_q <= '0;
            if (len != '0) begin
              addr  <= base;
              rem   <= len;
              state <= ST_RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (abort) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
          end else if (finish) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else if ((state == ST_RUN) && (rem == '0) && !inflight) begin
            state <= ST_DRAIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ej32_mem_dump.sv
// Scoreboard bench for ej32_mem_dump: stimulus queues expected bytes and done
// counts, an independent negedge monitor pops and compares them.
module tb_ej32_mem_dump;

  localparam int ASZ    = 17;
  localparam int FIFO_D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ASZ-1:0] base;
  logic [ASZ-1:0] len;
  logic           abort;
  logic           busy;
  logic           done;
  logic [ASZ-1:0] mem_a;
  logic           mem_re;
  logic [7:0]     mem_d;
  logic [7:0]     tx_d;
  logic           tx_vld;
  logic           tx_rdy;
  logic [ASZ-1:0] sent;

  logic [7:0] ram [0:(1<<ASZ)-1];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]     exp_q[$];
  int             exp_done[$];
  logic [ASZ-1:0] re_log[$];
  int             hs_count    = 0;
  int             outstanding = 0;
  bit             prev_stall  = 1'b0;
  logic [7:0]     prev_d      = 8'h00;

  ej32_mem_dump #(.ASZ(ASZ), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .abort(abort),
    .busy(busy), .done(done), .mem_a(mem_a), .mem_re(mem_re), .mem_d(mem_d),
    .tx_d(tx_d), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .sent(sent)
  );

  always #5 clk = ~clk;

  // Synchronous SPRAM model: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_re) mem_d <= ram[mem_a];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    bit pop_now;
    if (rst) begin
      exp_q.delete();
      exp_done.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      pop_now = tx_vld && tx_rdy && !abort;
      if (prev_stall) begin
        check("tx_vld_held", tx_vld, 1);
        check("tx_d_held", tx_d, prev_d);
      end
      if (pop_now) begin
        check("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_byte", tx_d, exp_q.pop_front());
        hs_count++;
      end
      if (mem_re) begin
        check("mem_re_room", (outstanding - int'(pop_now)) < FIFO_D, 1);
        re_log.push_back(mem_a);
      end
      outstanding += int'(mem_re) - int'(pop_now);
      if (abort) outstanding = 0;
      if (done) begin
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) check("sent_at_done", sent, exp_done.pop_front());
      end
      prev_stall = tx_vld && !tx_rdy && !abort;
      prev_d     = tx_d;
    end
  end

  task automatic do_start(input logic [ASZ-1:0] b, input logic [ASZ-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle k=0 is the first cycle after start is accepted.
  task automatic wait_done(input int max_cyc, input bit bp,
                           output int first_vld, output int done_k, output logic busy0);
    first_vld = -1; done_k = -1; busy0 = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (first_vld < 0 && tx_vld) first_vld = k;
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
      if (bp) tx_rdy = ((k + 1) % 3 == 0);
    end
    check("done_seen", done_k >= 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fv, dk, r0, hs0;
    logic b0;
    rst = 1'b1; start = 1'b0; base = '0; len = '0; abort = 1'b0; tx_rdy = 1'b1;
    ram[17'h01400] = 8'h11; ram[17'h01401] = 8'h22;
    ram[17'h01402] = 8'h33; ram[17'h01403] = 8'h44;
    ram[17'h1FFFF] = 8'hA5; ram[17'h00000] = 8'h5A;
    for (int i = 0; i < 16; i++) ram[17'h02000 + i] = 8'h80 + 8'(i);
    for (int i = 0; i < 8; i++)  ram[17'h03000 + i] = 8'hC0 + 8'(i);

    #23 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_tx_d", tx_d, 0);
    check("rst_tx_vld", tx_vld, 0);
    check("rst_sent", sent, 0);

    // Basic
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_done.push_back(4);
    do_start(17'h01400, 17'd4);
    wait_done(50, 1'b0, fv, dk, b0);
    check("basic_busy_c0", b0, 1);
    check("basic_first_vld", fv, 2);
    check("basic_done_cycle", dk, 6);
    check("basic_busy_at_done", busy, 0);
    check("basic_sent", sent, 4);

    // Backpressure 1,0,0,...
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_done.push_back(4);
    tx_rdy = 1'b1;
    do_start(17'h01400, 17'd4);
    wait_done(80, 1'b1, fv, dk, b0);
    check("bp_sent", sent, 4);
    tx_rdy = 1'b1;

    // Zero length
    r0 = re_log.size();
    exp_done.push_back(0);
    do_start(17'h00100, 17'd0);
    @(negedge clk);
    check("zl_done", done, 1);
    check("zl_busy0", busy, 0);
    check("zl_sent", sent, 0);
    @(negedge clk);
    check("zl_busy1", busy, 0);
    check("zl_no_read", re_log.size(), r0);

    // Address wrap
    r0 = re_log.size();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_done.push_back(2);
    do_start(17'h1FFFF, 17'd2);
    wait_done(50, 1'b0, fv, dk, b0);
    check("wrap_reads", re_log.size() - r0, 2);
    if (re_log.size() >= r0 + 2) begin
      check("wrap_a0", re_log[r0], 17'h1FFFF);
      check("wrap_a1", re_log[r0+1], 17'h00000);
    end

    // Abort after the 5th handshake
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h80 + 8'(i));
    hs0 = hs_count;
    do_start(17'h02000, 17'd16);
    for (int k = 0; k < 50 && (hs_count - hs0) < 5; k++) begin
      @(negedge clk); #1;
    end
    check("abort_hs_reached", hs_count - hs0, 5);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_tx_vld", tx_vld, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sent", sent, 5);
    check("abort_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    exp_q.push_back(8'h80);
    exp_done.push_back(1);
    do_start(17'h02000, 17'd1);
    wait_done(50, 1'b0, fv, dk, b0);
    check("post_abort_sent", sent, 1);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hC0 + 8'(i));
    do_start(17'h03000, 17'd8);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_mem_a", mem_a, 0);
    check("mr_mem_re", mem_re, 0);
    check("mr_tx_d", tx_d, 0);
    check("mr_tx_vld", tx_vld, 0);
    check("mr_sent", sent, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    r0 = re_log.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mr_idle_vld", tx_vld, 0);
    end
    check("mr_no_read", re_log.size(), r0);

    check("final_q_empty", exp_q.size(), 0);
    check("final_done_q_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
